vsm_relu_collector: RTL and testbench
=====================================

# vsm_relu_collector

Downstream stage of the vector-scalar multiplier. It counts the multiplier's `enable` pulses to know when a SIZE-lane accumulation is complete, and captures the lane vector one cycle after the final enable. It then applies per-lane ReLU, rounding right-shift and saturation. The requantized vector goes into a 2-entry output FIFO, which feeds the next layer through a valid/ready handshake.

## Interface
- `SIZE`, 6, number of lanes (matches the multiplier's SIZE)
- `WIDTH`, 8, lane width in bits; lanes are two's-complement signed
- `ACCUMULATIONS`, 3, enable pulses per complete result (≥1)
- `SHIFT`, 0, requantization right-shift (0..WIDTH-1)

- `clk` input 1: single clock, rising edge
- `reset` input 1: synchronous, active-high
- `enable` input 1: same enable that drives the multiplier
- `vec_in` input WIDTH*SIZE: multiplier output vector; lane i is `[WIDTH*i +: WIDTH]`
- `can_accept` output 1: high when the FIFO has a free entry for the next result; the upstream controller must not start a new accumulation group while it is low
- `out_valid` output 1: FIFO head valid
- `out_ready` input 1: consumer accepts the head
- `out_vec` output WIDTH*SIZE: requantized vector at the FIFO head
- `overflow` output 1: sticky; set when a result completes while the FIFO is full

## Operation
- Reset values:
  - `acc_cnt`=0 and `capture_pend`=0.
  - FIFO is empty, so `out_valid`=0 and `can_accept`=1.
  - `out_vec`=0 and `overflow`=0.
- Counter behaviour (`acc_cnt`, 0..ACCUMULATIONS-1):
  - Increments on each cycle with `enable`=1.
  - When it is at ACCUMULATIONS-1 with `enable`=1, it wraps to 0 and sets `capture_pend` for exactly one cycle.
- Capture: in the cycle `capture_pend`=1, `vec_in` holds the final accumulation. This cycle is T+1, where T is the last enable cycle. The block requantizes the vector and pushes it into the FIFO.
- Per-lane requantize, as signed WIDTH in, WIDTH out:
  - If x<0, the result is 0 (ReLU).
  - Otherwise y = (x + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >> SHIFT. The add is computed at WIDTH+1 bits.
  - y is clamped to 2^(WIDTH-1)-1, so x=127 with SHIFT=1 gives 64, not -64.
- FIFO:
  - 2 entries, first in first out.
  - push = `capture_pend`; pop = `out_valid && out_ready`.
- Push and pop in the same cycle:
  - Allowed when the FIFO is full.
  - Allowed when it is empty; the data then appears at the head next cycle, with no fall-through.
- Push while full with no pop in the same cycle:
  - The new vector is dropped and `overflow` is set.
  - `overflow` is cleared only by `reset`.
- `can_accept` is 1 when occupancy ≤1 and no capture is pending. It is registered.
- Reset mid-group clears the count: a partial accumulation is discarded and the next ACCUMULATIONS enables form a fresh group.

## Timing
- Latency: last enable at cycle T → capture at T+1 → `out_valid`=1 and `out_vec` valid at T+2.
- Throughput: one vector per ACCUMULATIONS cycles, sustained with `out_ready`=1. With ACCUMULATIONS=1 this is one vector per cycle.
- `out_vec`/`out_valid` hold stable while `out_valid && !out_ready`.
- `out_valid`, `out_vec`, `can_accept` and `overflow` are all registered; there is no combinational path from inputs to outputs.
- `enable` during T+1 counts toward the next group and does not disturb the capture.

## Structure
- Shared package `nn_pkg`: `LANE_W`=8, the default `VEC_LANES`=6, and a `lane_t` signed typedef.
- Sub-module `relu_requant`, one instance per lane in a generate loop:
  - Combinational.
  - Parameters WIDTH and SHIFT.
  - Ports `x_in` and `y_out`.
- FIFO state lives in this module: two registers plus 2-bit occupancy, read/write pointers.

## Test plan
- Basic group, defaults: 3 enables, with lane values at T+1 = {5,-3,127,0,-128,64} → at T+2 `out_valid`=1 and `out_vec` = {5,0,127,0,0,64}.
- Rounding and saturation, SHIFT=2, ACCUMULATIONS=1, single-cycle enable pulse:
  - Lanes {6,5,127,-1,2,1} → {2,1,32,0,1,0}.
- Backpressure: `out_ready`=0 while 2 groups complete → `can_accept`=0 and the head holds the first result. A third group then completes → `overflow`=1 and only the first two results are drained, in order.
- Simultaneous push/pop on a full FIFO with `out_ready`=1 at the capture cycle → no overflow, occupancy stays 2, order preserved.
- Back-to-back with ACCUMULATIONS=1: `enable` held high for 10 cycles with `out_ready`=1 → 10 vectors out on consecutive cycles, first at T+2.
- Reset mid-group: 2 enables, then `reset` → all outputs at reset values. 3 further enables then produce exactly one result.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared lane types and default vector geometry for the NN datapath blocks.
package nn_pkg;

    localparam int unsigned LANE_W    = 8;
    localparam int unsigned VEC_LANES = 6;

    typedef logic signed [LANE_W-1:0] lane_t;

endpackage : nn_pkg

// File: rtl/relu_requant.sv
// Per-lane ReLU, rounding right-shift and positive saturation (combinational).
module relu_requant
    import nn_pkg::*;
#(
    parameter int unsigned WIDTH = LANE_W,
    parameter int unsigned SHIFT = 0
) (
    input  logic signed [WIDTH-1:0] x_in,
    output logic signed [WIDTH-1:0] y_out
);

    localparam int unsigned SUM_W = WIDTH + 1;
    // Half-LSB rounding constant; collapses to zero when no shift is applied.
    localparam logic [SUM_W-1:0] RND   = SUM_W'((2 ** SHIFT) >> 1);
    localparam logic [SUM_W-1:0] Y_MAX = SUM_W'((2 ** (WIDTH - 1)) - 1);

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] shifted;

    always_comb begin
        sum     = {1'b0, x_in} + RND;
        shifted = sum >> SHIFT;
        if (x_in[WIDTH-1]) begin
            y_out = '0;
        end else if (shifted > Y_MAX) begin
            y_out = WIDTH'(Y_MAX);
        end else begin
            y_out = WIDTH'(shifted);
        end
    end

endmodule : relu_requant

// File: rtl/vsm_relu_collector.sv
// Counts multiplier enables, captures the finished lane vector, requantizes it
// and queues it in a 2-entry FIFO toward the next layer.
module vsm_relu_collector
    import nn_pkg::*;
#(
    parameter int unsigned SIZE          = VEC_LANES,
    parameter int unsigned WIDTH         = LANE_W,
    parameter int unsigned ACCUMULATIONS = 3,
    parameter int unsigned SHIFT         = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WIDTH*SIZE-1:0] vec_in,
    output logic                  can_accept,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH*SIZE-1:0] out_vec,
    output logic                  overflow
);

    localparam int unsigned VEC_W = WIDTH * SIZE;
    localparam int unsigned CNT_W = (ACCUMULATIONS > 1) ? $clog2(ACCUMULATIONS) : 1;

    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             capture_pend_q, capture_pend_d;
    logic [VEC_W-1:0] mem_q [2];
    logic [VEC_W-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             out_valid_q, out_valid_d;
    logic [VEC_W-1:0] out_vec_q, out_vec_d;
    logic             can_accept_q, can_accept_d;
    logic             overflow_q, overflow_d;

    logic [VEC_W-1:0] req_vec;
    logic             last_en;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;

    for (genvar i = 0; i < int'(SIZE); i++) begin : g_lane
        relu_requant #(
            .WIDTH (WIDTH),
            .SHIFT (SHIFT)
        ) u_relu (
            .x_in  (vec_in[WIDTH*i +: WIDTH]),
            .y_out (req_vec[WIDTH*i +: WIDTH])
        );
    end

    // Group counter, FIFO bookkeeping and next values of the registered outputs.
    always_comb begin
        acc_cnt_d      = acc_cnt_q;
        capture_pend_d = 1'b0;
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occ_d          = occ_q;
        overflow_d     = overflow_q;

        last_en = enable && (acc_cnt_q == CNT_W'(ACCUMULATIONS - 1));
        if (enable) begin
            acc_cnt_d = last_en ? '0 : acc_cnt_q + CNT_W'(1);
        end
        capture_pend_d = last_en;

        push    = capture_pend_q;
        pop     = out_valid_q && out_ready;
        full    = (occ_q == 2'd2);
        // A pop in the same cycle frees the slot the push lands in.
        push_ok = push && (!full || pop);

        if (push_ok) begin
            mem_d[wr_ptr_q] = req_vec;
        end
        wr_ptr_d   = wr_ptr_q ^ push_ok;
        rd_ptr_d   = rd_ptr_q ^ pop;
        occ_d      = occ_q + 2'(push_ok) - 2'(pop);
        overflow_d = overflow_q | (push && full && !pop);

        out_valid_d  = (occ_d != 2'd0);
        out_vec_d    = mem_d[rd_ptr_d];
        can_accept_d = (occ_d != 2'd2) && !capture_pend_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt_q      <= '0;
            capture_pend_q <= 1'b0;
            mem_q[0]       <= '0;
            mem_q[1]       <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            occ_q          <= 2'd0;
            out_valid_q    <= 1'b0;
            out_vec_q      <= '0;
            can_accept_q   <= 1'b1;
            overflow_q     <= 1'b0;
        end else begin
            acc_cnt_q      <= acc_cnt_d;
            capture_pend_q <= capture_pend_d;
            mem_q[0]       <= mem_d[0];
            mem_q[1]       <= mem_d[1];
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            out_valid_q    <= out_valid_d;
            out_vec_q      <= out_vec_d;
            can_accept_q   <= can_accept_d;
            overflow_q     <= overflow_d;
        end
    end

    assign can_accept = can_accept_q;
    assign out_valid  = out_valid_q;
    assign out_vec    = out_vec_q;
    assign overflow   = overflow_q;

endmodule : vsm_relu_collector

// File: tb/tb_vsm_relu_collector.sv
// Bench for vsm_relu_collector: default instance plus a SHIFT=2/ACCUMULATIONS=1 instance.
module tb_vsm_relu_collector;

    localparam int unsigned VW = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          en      [2];
    logic [VW-1:0] vin     [2];
    logic          rdy     [2];
    logic          can_acc [2];
    logic          ovld    [2];
    logic [VW-1:0] ovec    [2];
    logic          ovf     [2];

    int n_checks = 0;
    int n_fail   = 0;

    vsm_relu_collector u_a (
        .clk        (clk),
        .reset      (reset),
        .enable     (en[0]),
        .vec_in     (vin[0]),
        .can_accept (can_acc[0]),
        .out_valid  (ovld[0]),
        .out_ready  (rdy[0]),
        .out_vec    (ovec[0]),
        .overflow   (ovf[0])
    );

    vsm_relu_collector #(
        .ACCUMULATIONS (1),
        .SHIFT         (2)
    ) u_b (
        .clk        (clk),
        .reset      (reset),
        .enable     (en[1]),
        .vec_in     (vin[1]),
        .can_accept (can_acc[1]),
        .out_valid  (ovld[1]),
        .out_ready  (rdy[1]),
        .out_vec    (ovec[1]),
        .overflow   (ovf[1])
    );

    function automatic int acc_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic int sh_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic [VW-1:0] requant(input logic [VW-1:0] v, input int sh);
        logic [VW-1:0] r;
        int x;
        int y;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            x = $signed(v[8*i +: 8]);
            if (x < 0) y = 0;
            else y = (x + ((sh > 0) ? (1 << (sh - 1)) : 0)) / (1 << sh);
            if (y > 127) y = 127;
            r[8*i +: 8] = 8'(y);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] pack6(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5);
        logic [VW-1:0] r;
        r = {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        return r;
    endfunction

    task automatic check(input string nm, input int k, input logic [VW-1:0] act,
                         input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, k, $time, act, exp);
        end
    endtask

    // Behavioural model: count enables, capture next cycle, queue of at most two results.
    logic [VW-1:0] mq [2][$];
    int            m_cnt  [2];
    bit            m_pend [2];
    bit            m_ovf  [2];
    bit            m_zero [2];
    bit            started = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit            pop;
            bit            push;
            logic [VW-1:0] v;
            if (reset) begin
                mq[k].delete();
                m_cnt[k]  = 0;
                m_pend[k] = 1'b0;
                m_ovf[k]  = 1'b0;
                m_zero[k] = 1'b1;
            end else begin
                pop  = (mq[k].size() > 0) && rdy[k];
                push = 1'b0;
                v    = '0;
                if (m_pend[k]) begin
                    v    = requant(vin[k], sh_of(k));
                    push = (mq[k].size() < 2) || pop;
                    if (!push) m_ovf[k] = 1'b1;
                end
                if (pop) void'(mq[k].pop_front());
                if (push) begin
                    mq[k].push_back(v);
                    m_zero[k] = 1'b0;
                end
                m_pend[k] = en[k] && (m_cnt[k] == acc_of(k) - 1);
                if (en[k]) m_cnt[k] = (m_cnt[k] + 1) % acc_of(k);
            end
        end
        started = 1'b1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                check("out_valid", k, VW'(ovld[k]), VW'(mq[k].size() > 0));
                check("can_accept", k, VW'(can_acc[k]), VW'((mq[k].size() <= 1) && !m_pend[k]));
                check("overflow", k, VW'(ovf[k]), VW'(m_ovf[k]));
                if (mq[k].size() > 0) check("out_vec", k, ovec[k], mq[k][0]);
                else if (m_zero[k]) check("out_vec_rst", k, ovec[k], '0);
            end
        end
    end

    task automatic check_reset_state(input string nm);
        for (int k = 0; k < 2; k++) begin
            check({nm, "_valid"}, k, VW'(ovld[k]), '0);
            check({nm, "_canacc"}, k, VW'(can_acc[k]), VW'(1));
            check({nm, "_vec"}, k, ovec[k], '0);
            check({nm, "_ovf"}, k, VW'(ovf[k]), '0);
        end
    endtask

    task automatic group_a(input logic [VW-1:0] v);
        en[0]  = 1'b1;
        vin[0] = v;
        repeat (3) @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int first;
        int last;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en[k]  = 1'b0;
            vin[k] = '0;
            rdy[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Basic group on the default instance.
        en[0]  = 1'b1;
        vin[0] = pack6(5, -3, 127, 0, -128, 64);
        repeat (3) @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        check("basic_valid", 0, VW'(ovld[0]), VW'(1));
        check("basic_vec", 0, ovec[0], pack6(5, 0, 127, 0, 0, 64));
        @(negedge clk);

        // Rounding with SHIFT=2 on the single-enable instance.
        en[1]  = 1'b1;
        vin[1] = pack6(6, 5, 127, -1, 2, 1);
        @(negedge clk);
        en[1] = 1'b0;
        @(negedge clk);
        check("round_valid", 1, VW'(ovld[1]), VW'(1));
        check("round_vec", 1, ovec[1], pack6(2, 1, 32, 0, 1, 0));
        @(negedge clk);

        // Backpressure, then overflow on a third group.
        rdy[0] = 1'b0;
        group_a(pack6(10, 10, 10, 10, 10, 10));
        group_a(pack6(20, 20, 20, 20, 20, 20));
        check("bp_canacc", 0, VW'(can_acc[0]), '0);
        check("bp_head", 0, ovec[0], pack6(10, 10, 10, 10, 10, 10));
        group_a(pack6(30, 30, 30, 30, 30, 30));
        check("bp_ovf", 0, VW'(ovf[0]), VW'(1));
        rdy[0] = 1'b1;
        check("bp_drain0", 0, ovec[0], pack6(10, 10, 10, 10, 10, 10));
        @(negedge clk);
        check("bp_drain1", 0, ovec[0], pack6(20, 20, 20, 20, 20, 20));
        @(negedge clk);
        check("bp_empty", 0, VW'(ovld[0]), '0);

        // Push and pop together on a full FIFO.
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        rdy[0] = 1'b0;
        group_a(pack6(10, 10, 10, 10, 10, 10));
        group_a(pack6(20, 20, 20, 20, 20, 20));
        en[0]  = 1'b1;
        vin[0] = pack6(30, 30, 30, 30, 30, 30);
        repeat (3) @(negedge clk);
        en[0]  = 1'b0;
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        check("pp_ovf", 0, VW'(ovf[0]), '0);
        check("pp_canacc", 0, VW'(can_acc[0]), '0);
        check("pp_head", 0, ovec[0], pack6(20, 20, 20, 20, 20, 20));
        rdy[0] = 1'b1;
        @(negedge clk);
        check("pp_next", 0, ovec[0], pack6(30, 30, 30, 30, 30, 30));
        @(negedge clk);
        check("pp_empty", 0, VW'(ovld[0]), '0);

        // Back-to-back single-enable results.
        cnt   = 0;
        first = -1;
        last  = -1;
        rdy[1] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            en[1] = (c < 10);
            vin[1] = VW'({$urandom(), $urandom()});
            @(negedge clk);
            if (ovld[1]) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        check("b2b_count", 1, VW'(cnt), VW'(10));
        check("b2b_first", 1, VW'(first), VW'(1));
        check("b2b_span", 1, VW'(last - first), VW'(9));

        // Reset in the middle of a group discards the partial count.
        rdy[0] = 1'b1;
        en[0]  = 1'b1;
        vin[0] = VW'({$urandom(), $urandom()});
        repeat (2) @(negedge clk);
        en[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            en[0] = (c < 3);
            @(negedge clk);
            if (ovld[0]) cnt++;
        end
        check("midrst_count", 0, VW'(cnt), VW'(1));

        // Randomized traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < 2; k++) begin
                en[k]  = ($urandom_range(0, 3) != 0);
                rdy[k] = ($urandom_range(0, 3) != 0);
                vin[k] = VW'({$urandom(), $urandom()});
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vsm_relu_collector
